// File: rtl/assign_if_pkg.sv
// Shared types and constants for the assign/if mux scoreboard.
package assign_if_pkg;

    localparam int unsigned DEF_W     = 2;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHECK  = 2'b01,
        REPORT = 2'b10
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_C    = 2'b01;
    localparam logic [1:0] ERR_D    = 2'b10;
    localparam logic [1:0] ERR_BOTH = 2'b11;

endpackage

// File: rtl/assign_if_scoreboard_if.sv
// Sample input and error-report handshake bundle of the scoreboard.
interface assign_if_scoreboard_if import assign_if_pkg::*; #(
    parameter int unsigned W = DEF_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] c;
    logic [W-1:0] d;

    logic         err_valid;
    logic         err_ready;
    logic [1:0]   err_code;
    logic [W-1:0] err_exp;
    logic [W-1:0] err_c;
    logic [W-1:0] err_d;

    modport master (
        output in_valid, a, b, sel, c, d, err_ready,
        input  in_ready, err_valid, err_code, err_exp, err_c, err_d
    );

    modport slave (
        input  in_valid, a, b, sel, c, d, err_ready,
        output in_ready, err_valid, err_code, err_exp, err_c, err_d
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/assign_if_scoreboard.sv
// Checks an assign-style and an if-style 2:1 mux against sel ? a : b and
// reports mismatches over a valid/ready error channel.
module assign_if_scoreboard import assign_if_pkg::*; #(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    assign_if_scoreboard_if.slave bus,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [CNT_W-1:0]      diverge_cnt
);

    state_e       state;
    logic [W-1:0] exp_q;
    logic [W-1:0] c_q;
    logic [W-1:0] d_q;
    logic [1:0]   mis_code;
    logic         checking;
    logic         accept;

    // Comparison works on the held sample, so in_ready depends on registers only.
    assign mis_code     = {(d_q != exp_q), (c_q != exp_q)};
    assign checking     = (state == CHECK);
    assign bus.in_ready = (state == IDLE) || (checking && (mis_code == ERR_NONE));
    assign accept       = bus.in_valid && bus.in_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            exp_q        <= '0;
            c_q          <= '0;
            d_q          <= '0;
            bus.err_valid <= 1'b0;
            bus.err_code  <= ERR_NONE;
            bus.err_exp   <= '0;
            bus.err_c     <= '0;
            bus.err_d     <= '0;
        end else if (clear) begin
            state         <= IDLE;
            bus.err_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        exp_q <= bus.sel ? bus.a : bus.b;
                        c_q   <= bus.c;
                        d_q   <= bus.d;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mis_code != ERR_NONE) begin
                        state         <= REPORT;
                        bus.err_valid <= 1'b1;
                        bus.err_code  <= mis_code;
                        bus.err_exp   <= exp_q;
                        bus.err_c     <= c_q;
                        bus.err_d     <= d_q;
                    end else if (accept) begin
                        exp_q <= bus.sel ? bus.a : bus.b;
                        c_q   <= bus.c;
                        d_q   <= bus.d;
                    end else begin
                        state <= IDLE;
                    end
                end
                REPORT: begin
                    // err_data keeps its last value after the handshake.
                    if (bus.err_ready) begin
                        bus.err_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.err_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (checking),
        .clr   (clear),
        .cnt   (sample_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_mismatch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (checking && (mis_code != ERR_NONE)),
        .clr   (clear),
        .cnt   (mismatch_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_diverge_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (checking && (c_q != d_q)),
        .clr   (clear),
        .cnt   (diverge_cnt)
    );

endmodule

// File: tb/tb_assign_if_scoreboard.sv
// Directed bench: expected error reports queue up at issue and a negedge monitor
// checks each one at its handshake; counters and handshake levels checked inline.
module tb_assign_if_scoreboard;
    import assign_if_pkg::*;

    localparam int unsigned W = 2;

    typedef struct packed {
        logic [1:0]   code;
        logic [W-1:0] exp;
        logic [W-1:0] c;
        logic [W-1:0] d;
    } rpt_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] sample_cnt, mismatch_cnt, diverge_cnt;
    logic [1:0] s_sample_cnt, s_mismatch_cnt, s_diverge_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    rpt_t exp_rpt[$];
    rpt_t mon_r;

    logic [8:0] b2b [4] = '{
        {1'b0, 2'd0, 2'd1, 2'd1, 2'd1},
        {1'b1, 2'd3, 2'd0, 2'd3, 2'd3},
        {1'b0, 2'd2, 2'd0, 2'd0, 2'd0},
        {1'b1, 2'd1, 2'd1, 2'd1, 2'd1}
    };

    always #5 clk = ~clk;

    assign_if_scoreboard_if #(.W(W)) bus ();
    assign_if_scoreboard_if #(.W(W)) bus_s ();

    assign_if_scoreboard #(.W(W), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .bus          (bus),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .diverge_cnt  (diverge_cnt)
    );

    assign_if_scoreboard #(.W(W), .CNT_W(2)) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .bus          (bus_s),
        .sample_cnt   (s_sample_cnt),
        .mismatch_cnt (s_mismatch_cnt),
        .diverge_cnt  (s_diverge_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] code, input logic [W-1:0] e, input logic [W-1:0] vc,
                        input logic [W-1:0] vd);
        rpt_t r;
        r.code = code;
        r.exp  = e;
        r.c    = vc;
        r.d    = vd;
        exp_rpt.push_back(r);
    endtask

    task automatic send(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] vc, input logic [W-1:0] vd);
        int waited = 0;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 1);
        {bus.sel, bus.a, bus.b, bus.c, bus.d} = {s, va, vb, vc, vd};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_s(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] vc, input logic [W-1:0] vd);
        int waited = 0;
        while (!bus_s.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus_s.in_ready) check("s_in_ready_timeout", 32'(bus_s.in_ready), 1);
        {bus_s.sel, bus_s.a, bus_s.b, bus_s.c, bus_s.d} = {s, va, vb, vc, vd};
        bus_s.in_valid = 1'b1;
        tick();
        bus_s.in_valid = 1'b0;
    endtask

    // A valid&&ready seen at negedge completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.err_valid && bus.err_ready) begin
            check("report_expected", 32'(exp_rpt.size() != 0), 1);
            if (exp_rpt.size() != 0) begin
                mon_r = exp_rpt.pop_front();
                check("err_code", 32'(bus.err_code), 32'(mon_r.code));
                check("err_exp", 32'(bus.err_exp), 32'(mon_r.exp));
                check("err_c", 32'(bus.err_c), 32'(mon_r.c));
                check("err_d", 32'(bus.err_d), 32'(mon_r.d));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        {bus.in_valid, bus.sel, bus.a, bus.b, bus.c, bus.d} = '0;
        bus.err_ready = 1'b1;
        {bus_s.in_valid, bus_s.sel, bus_s.a, bus_s.b, bus_s.c, bus_s.d} = '0;
        bus_s.err_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_err_valid", 32'(bus.err_valid), 0);
        check("rst_err_code", 32'(bus.err_code), 0);
        check("rst_err_exp", 32'(bus.err_exp), 0);
        check("rst_sample_cnt", 32'(sample_cnt), 0);
        check("rst_mismatch_cnt", 32'(mismatch_cnt), 0);
        rst_n = 1'b1;

        // Matching sample, accepted on the first edge after reset release
        send(1'b0, 2'd2, 2'd3, 2'd3, 2'd3);
        check("match_in_ready", 32'(bus.in_ready), 1);
        tick();
        check("match_sample_cnt", 32'(sample_cnt), 1);
        check("match_err_valid", 32'(bus.err_valid), 0);
        check("match_mismatch_cnt", 32'(mismatch_cnt), 0);
        check("match_diverge_cnt", 32'(diverge_cnt), 0);

        // d wrong, report held with err_ready low
        bus.err_ready = 1'b0;
        push(2'b10, 2'd2, 2'd2, 2'd3);
        send(1'b1, 2'd2, 2'd3, 2'd2, 2'd3);
        check("mis_in_ready", 32'(bus.in_ready), 0);
        check("mis_err_valid_early", 32'(bus.err_valid), 0);
        tick();
        check("mis_err_valid", 32'(bus.err_valid), 1);
        check("mis_mismatch_cnt", 32'(mismatch_cnt), 1);
        check("mis_diverge_cnt", 32'(diverge_cnt), 1);
        check("mis_sample_cnt", 32'(sample_cnt), 2);
        {bus.sel, bus.a, bus.b, bus.c, bus.d} = {1'b0, 2'd0, 2'd0, 2'd1, 2'd1};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_err_valid", 32'(bus.err_valid), 1);
            check("hold_err_code", 32'(bus.err_code), 2);
            check("hold_err_d", 32'(bus.err_d), 3);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.err_ready = 1'b1;
        tick();
        check("ack_err_valid", 32'(bus.err_valid), 0);
        check("ack_in_ready", 32'(bus.in_ready), 1);
        check("ack_err_code_held", 32'(bus.err_code), 2);
        check("ack_sample_cnt", 32'(sample_cnt), 2);

        // Four back-to-back matching samples
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {bus.sel, bus.a, bus.b, bus.c, bus.d} = b2b[i];
            tick();
            check("b2b_in_ready", 32'(bus.in_ready), 1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("b2b_sample_cnt", 32'(sample_cnt), 6);
        check("b2b_mismatch_cnt", 32'(mismatch_cnt), 1);

        // Both wrong, c wrong, both wrong but equal (no divergence)
        push(2'b11, 2'd2, 2'd0, 2'd3);
        send(1'b0, 2'd1, 2'd2, 2'd0, 2'd3);
        push(2'b01, 2'd3, 2'd1, 2'd3);
        send(1'b1, 2'd3, 2'd0, 2'd1, 2'd3);
        push(2'b11, 2'd1, 2'd2, 2'd2);
        send(1'b0, 2'd0, 2'd1, 2'd2, 2'd2);
        repeat (4) tick();
        check("mix_sample_cnt", 32'(sample_cnt), 9);
        check("mix_mismatch_cnt", 32'(mismatch_cnt), 4);
        check("mix_diverge_cnt", 32'(diverge_cnt), 3);
        check("mix_queue_empty", 32'(exp_rpt.size()), 0);

        // Asynchronous reset in the middle of a pending report
        bus.err_ready = 1'b0;
        send(1'b1, 2'd1, 2'd0, 2'd0, 2'd1);
        tick();
        check("pre_rst_err_valid", 32'(bus.err_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_err_valid", 32'(bus.err_valid), 0);
        check("arst_err_code", 32'(bus.err_code), 0);
        check("arst_sample_cnt", 32'(sample_cnt), 0);
        check("arst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Clear during a pending report
        send(1'b1, 2'd1, 2'd0, 2'd0, 2'd1);
        tick();
        check("pre_clr_err_valid", 32'(bus.err_valid), 1);
        check("pre_clr_mismatch_cnt", 32'(mismatch_cnt), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_err_valid", 32'(bus.err_valid), 0);
        check("clr_in_ready", 32'(bus.in_ready), 1);
        check("clr_sample_cnt", 32'(sample_cnt), 0);
        check("clr_mismatch_cnt", 32'(mismatch_cnt), 0);
        check("clr_diverge_cnt", 32'(diverge_cnt), 0);

        // Clear beats the increment of a sample under check
        send(1'b0, 2'd2, 2'd3, 2'd3, 2'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_prio_sample_cnt", 32'(sample_cnt), 0);

        // Clear discards a same-cycle accept
        {bus.sel, bus.a, bus.b, bus.c, bus.d} = {1'b0, 2'd2, 2'd3, 2'd3, 2'd3};
        bus.in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("clr_accept_sample_cnt", 32'(sample_cnt), 0);
        bus.err_ready = 1'b1;

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) send_s(1'b1, 2'd1, 2'd0, 2'd0, 2'd1);
        repeat (4) tick();
        check("sat_mismatch_cnt", 32'(s_mismatch_cnt), 3);
        check("sat_sample_cnt", 32'(s_sample_cnt), 3);
        check("sat_diverge_cnt", 32'(s_diverge_cnt), 3);

        check("final_queue_empty", 32'(exp_rpt.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/assign_if_scoreboard.md
ASSIGN_IF_SCOREBOARD -- requirements
Module: assign_if_scoreboard

Interface
- REQ-001: Parameter W, default 2: data width of a, b, c, d.
- REQ-002: Parameter CNT_W, default 8: width of each statistics counter.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: clear  input  1  synchronous counter clear and report abort.
- REQ-006: in_valid  input  1  the sample on a, b, sel, c and d is valid.
- REQ-007: in_ready  output  1  the scoreboard can accept a sample.
- REQ-008: a, b  input  W  mux data inputs as driven to the design under check.
- REQ-009: sel  input  1  mux select as driven to the design under check.
- REQ-010: c, d  input  W  design outputs: c is the assign-style path, d is the if-style path.
- REQ-011: err_valid  output  1  an error report is pending.
- REQ-012: err_ready  input  1  the consumer accepts the error report.
- REQ-013: err_code  output  2  error type: 01 = c wrong, 10 = d wrong, 11 = both wrong.
- REQ-014: err_exp, err_c, err_d  output  W  expected value, captured c and captured d of the failing sample.
- REQ-015: sample_cnt, mismatch_cnt, diverge_cnt  output  CNT_W  statistics counters.

Function
- REQ-016: The expected value SHALL be exp = sel ? a : b, computed on the captured sample.
- REQ-017: A sample SHALL be accepted on a rising edge where in_valid && in_ready.
- REQ-018: The FSM SHALL have three states:
  - IDLE: no sample is held.
  - CHECK: one captured sample is held.
  - REPORT: an error is pending.
- REQ-019: IDLE SHALL go to CHECK on accept; otherwise it stays in IDLE.
- REQ-020: CHECK with a held mismatch SHALL go to REPORT.
- REQ-021: CHECK without a held mismatch SHALL stay in CHECK on a new accept, and go to IDLE otherwise.
- REQ-022: REPORT SHALL go to IDLE on the rising edge where err_valid && err_ready.
- REQ-023: in_ready SHALL be 1 in IDLE, 1 in CHECK when the held sample matches, and 0 otherwise; it is decoded combinationally from registered state only.
- REQ-024: Latency SHALL be as follows for a sample accepted at edge N:
  - it is compared while in CHECK after edge N;
  - sample_cnt increments at edge N+1;
  - on mismatch, err_valid goes to 1 after edge N+1.
- REQ-025: Mismatch SHALL be detected as follows:
  - bit0 of the code = (c != exp);
  - bit1 of the code = (d != exp);
  - any nonzero code increments mismatch_cnt at edge N+1.
- REQ-026: diverge_cnt SHALL increment at edge N+1 when c != d, independent of exp.
- REQ-027: err_valid, err_code, err_exp, err_c and err_d SHALL be registered and held stable until the handshake completes.
- REQ-028: After the handshake, err_valid SHALL drop at that same edge, and the err_* data SHALL hold its last value.
- REQ-029: All counters SHALL saturate at 2^CNT_W-1 and never wrap.
- REQ-030: clear SHALL take effect at the next edge:
  - all counters go to 0, with priority over a same-cycle increment;
  - the FSM goes to IDLE;
  - err_valid goes to 0;
  - a same-cycle accept is discarded.
- REQ-031: Samples presented while in_ready is 0 SHALL be ignored and not counted.

Reset
- REQ-032: Asserting rst_n low SHALL, without waiting for clk:
  - set the FSM to IDLE;
  - set err_valid to 0 and err_code to 00;
  - set err_exp, err_c and err_d to 0;
  - set all counters to 0.
- REQ-033: In-flight and pending reports SHALL be discarded by reset, including reset asserted mid-REPORT.
- REQ-034: The first accept after reset SHALL be possible on the first rising edge after rst_n deasserts.

Structure
- REQ-035: Package assign_if_pkg SHALL hold:
  - the state enum {IDLE, CHECK, REPORT};
  - the err_code constants ERR_C, ERR_D, ERR_BOTH;
  - the default W and CNT_W.
- REQ-036: One sub-module, sat_counter, SHALL be parameterized by CNT_W, have inc and clr inputs, and be instantiated three times.

Verification
- REQ-037: sel=0, a=10, b=11, c=11, d=11 -> sample_cnt=1, no err_valid, in_ready stays 1.
- REQ-038: sel=1, a=10, b=11, c=10, d=11 -> err_valid at N+1 with err_code=10, err_exp=10, err_d=11; mismatch_cnt=1 and diverge_cnt=1; in_ready=0 until err_ready.
- REQ-039: Back-to-back matching samples with in_valid held 1 for 4 cycles -> sample_cnt=4, with the FSM staying in CHECK throughout.
- REQ-040: Mismatch with err_ready held 0 for 5 cycles -> err_* stable, further samples ignored; err_ready=1 -> IDLE next edge.
- REQ-041: With CNT_W=2, 5 mismatching samples -> mismatch_cnt saturates at 3.
- REQ-042: Pending report followed by rst_n low mid-cycle -> err_valid=0 immediately; clear during REPORT -> IDLE and counters 0 next edge.
